// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Handshakes are active-low, so the constants name the asserted and deasserted levels.
package uart_tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  localparam logic ACT_N   = 1'b0;
  localparam logic INACT_N = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin selector.
// Searches last_grant+1, last_grant+2, ... (modulo NREQ) for the first active request.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Walk from the farthest candidate to the nearest so the nearest active one is kept.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = NREQ; i >= 1; i--) begin
      if (req[(int'(last_grant) + i) % NREQ]) begin
        valid = 1'b1;
        idx   = IW'((int'(last_grant) + i) % NREQ);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates NREQ byte-stream requesters onto one UART transmitter, holding the
// grant for a whole message and revoking it if the owner stalls too long.
module uart_tx_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 4340
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [NREQ*8-1:0]        req_data,
  input  logic [NREQ-1:0]          req_valid_n,
  input  logic [NREQ-1:0]          req_eop,
  output logic [NREQ-1:0]          req_ready_n,
  output logic [7:0]               tx_data,
  output logic                     tx_valid_n,
  input  logic                     tx_ready_n,
  output logic [$clog2(NREQ)-1:0]  grant_idx,
  output logic                     busy,
  output logic                     timeout_p
);

  import uart_tx_arbiter_pkg::*;

  localparam int          IW        = $clog2(NREQ);
  localparam logic [31:0] STALL_LIM = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  state_e          state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [31:0]     stall_q, stall_d;
  logic            pick_valid;
  logic [IW-1:0]   pick_idx;
  logic            own_valid;
  logic            xfer;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
    .req        (~req_valid_n),
    .last_grant (last_q),
    .valid      (pick_valid),
    .idx        (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    stall_d     = stall_q;
    timeout_p   = 1'b0;
    tx_data     = 8'h00;
    tx_valid_n  = INACT_N;
    req_ready_n = '1;
    own_valid   = (req_valid_n[grant_q] == ACT_N);
    xfer        = (state_q == ST_LOCKED) && own_valid && (tx_ready_n == ACT_N);

    case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (pick_valid) begin
          grant_d = pick_idx;
          state_d = ST_LOCKED;
        end
      end
      ST_LOCKED: begin
        tx_data              = req_data[int'(grant_q)*8 +: 8];
        tx_valid_n           = req_valid_n[grant_q];
        req_ready_n[grant_q] = tx_ready_n;
        // Only an absent byte from the owner counts as a stall; transmitter backpressure does not.
        if (xfer) begin
          stall_d = '0;
          if (req_eop[grant_q]) begin
            state_d = ST_IDLE;
            last_d  = grant_q;
          end
        end else if (!own_valid) begin
          if ((TIMEOUT > 0) && (stall_q >= STALL_LIM)) begin
            state_d   = ST_IDLE;
            last_d    = grant_q;
            timeout_p = 1'b1;
          end else if (stall_q != '1) begin
            stall_d = stall_q + 32'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ - 1);
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      stall_q <= stall_d;
    end
  end

  assign grant_idx = grant_q;
  assign busy      = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with two requesters and a short watchdog.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [15:0] req_data;
  logic [1:0]  req_valid_n;
  logic [1:0]  req_eop;
  logic [1:0]  req_ready_n;
  logic [7:0]  tx_data;
  logic        tx_valid_n;
  logic        tx_ready_n;
  logic        grant_idx;
  logic        busy;
  logic        timeout_p;

  int n_checks = 0;
  int n_errors = 0;

  uart_tx_arbiter #(.NREQ(2), .TIMEOUT(8)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .req_data    (req_data),
    .req_valid_n (req_valid_n),
    .req_eop     (req_eop),
    .req_ready_n (req_ready_n),
    .tx_data     (tx_data),
    .tx_valid_n  (tx_valid_n),
    .tx_ready_n  (tx_ready_n),
    .grant_idx   (grant_idx),
    .busy        (busy),
    .timeout_p   (timeout_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst       = 1'b0;
    req_data    = 16'h0000;
    req_valid_n = 2'b11;
    req_eop     = 2'b00;
    tx_ready_n  = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic to_seen;
    logic data_moved;

    // Reset state and a three-byte message from requester 0
    do_reset();
    n_rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid_n, 1);
    chk("rst_rdy", req_ready_n, 2'b11);
    chk("rst_grant", grant_idx, 0);
    chk("rst_to", timeout_p, 0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    req_data = 16'h0041; req_valid_n = 2'b10;
    #1;
    chk("idle_txv", tx_valid_n, 1);
    chk("idle_rdy", req_ready_n, 2'b11);
    tick();
    chk("m1_busy", busy, 1);
    chk("m1_b0", tx_data, 8'h41);
    chk("m1_txv", tx_valid_n, 0);
    chk("m1_rdy0", req_ready_n, 2'b10);
    tick();
    req_data = 16'h0042;
    #1;
    chk("m1_b1", tx_data, 8'h42);
    chk("m1_rdy1", req_ready_n, 2'b10);
    tick();
    req_data = 16'h0043; req_eop = 2'b01;
    #1;
    chk("m1_b2", tx_data, 8'h43);
    chk("m1_rdy2", req_ready_n, 2'b10);
    tick();
    req_valid_n = 2'b11; req_eop = 2'b00;
    #1;
    chk("m1_end_busy", busy, 0);

    // Both requesters valid from reset: 0, then 1, then 0 again
    do_reset();
    req_data = 16'hB1A0; req_valid_n = 2'b00; req_eop = 2'b11;
    tick();
    chk("rr_g0", grant_idx, 0);
    chk("rr_d0", tx_data, 8'hA0);
    tick();
    chk("rr_gap", busy, 0);
    tick();
    chk("rr_g1", grant_idx, 1);
    chk("rr_d1", tx_data, 8'hB1);
    chk("rr_rdy1", req_ready_n, 2'b01);
    tick();
    chk("rr_gap2", busy, 0);
    tick();
    chk("rr_g0b", grant_idx, 0);

    // Requester 0 raises valid while requester 1 is mid-message
    do_reset();
    req_data = 16'hC100; req_valid_n = 2'b01;
    tick();
    chk("mid_g1", grant_idx, 1);
    tick();
    req_valid_n = 2'b00; tx_ready_n = 1'b1;
    #1;
    chk("mid_rdy_bp", req_ready_n, 2'b11);
    tick();
    tx_ready_n = 1'b0; req_eop = 2'b10;
    #1;
    chk("mid_rdy_eop", req_ready_n, 2'b01);
    chk("mid_g1b", grant_idx, 1);
    tick();
    req_eop = 2'b00;
    #1;
    chk("mid_idle_rdy", req_ready_n, 2'b11);
    tick();
    chk("mid_g0", grant_idx, 0);
    chk("mid_rdy0", req_ready_n, 2'b10);

    // Watchdog: requester 0 sends one byte then goes silent
    do_reset();
    req_data = 16'h6655; req_valid_n = 2'b00;
    tick();
    chk("wd_g0", grant_idx, 0);
    tick();
    req_valid_n = 2'b01;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk($sformatf("wd_to_%0d", k), timeout_p, (k == 8) ? 1 : 0);
      if (k < 8) tick();
    end
    chk("wd_busy_hold", busy, 1);
    tick();
    chk("wd_busy_drop", busy, 0);
    chk("wd_to_clr", timeout_p, 0);
    tick();
    chk("wd_g1", grant_idx, 1);
    chk("wd_d1", tx_data, 8'h66);

    // Long transmitter backpressure must not trip the watchdog
    do_reset();
    req_data = 16'h0077; req_valid_n = 2'b10; req_eop = 2'b01; tx_ready_n = 1'b1;
    tick();
    to_seen = 1'b0; data_moved = 1'b0;
    for (int k = 0; k < 1000; k++) begin
      if (timeout_p) to_seen = 1'b1;
      if (tx_data !== 8'h77 || tx_valid_n !== 1'b0 || busy !== 1'b1) data_moved = 1'b1;
      tick();
    end
    chk("bp_no_to", to_seen, 0);
    chk("bp_stable", data_moved, 0);
    tx_ready_n = 1'b0;
    #1;
    chk("bp_rdy", req_ready_n, 2'b10);
    tick();
    chk("bp_done", busy, 0);

    // Reset asserted mid-message
    do_reset();
    req_data = 16'h5A33; req_valid_n = 2'b01;
    tick();
    chk("rm_g1", grant_idx, 1);
    tick();
    n_rst = 1'b0;
    #1;
    chk("rm_txv", tx_valid_n, 1);
    chk("rm_busy", busy, 0);
    chk("rm_rdy", req_ready_n, 2'b11);
    req_valid_n = 2'b00;
    @(posedge clk);
    #1 n_rst = 1'b1;
    #1;
    chk("rm_idle_txv", tx_valid_n, 1);
    tick();
    chk("rm_g0", grant_idx, 0);
    chk("rm_d0", tx_data, 8'h33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
